// File: rtl/cpu_mem_pkg.sv
// Shared types for the memory stage and MEM/WB pipeline register.
package cpu_mem_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_IDX_W = 5;

    // Data-memory access sequencer states
    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    // Writeback payload carried from MEM to WB
    typedef struct packed {
        logic                 wreg;
        logic                 m2reg;
        logic [DATA_W-1:0]    alu;
        logic [DATA_W-1:0]    mdata;
        logic [REG_IDX_W-1:0] rn;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: load, bubble or hold, with synchronous active-high clear.
// The load data field is written only when i_mdata_we is set, so it survives
// stores, ALU ops and bubbles.
module mem_wb_register
    import cpu_mem_pkg::*;
(
    input  logic    clk,
    input  logic    i_clr,
    input  logic    i_load,
    input  logic    i_bubble,
    input  logic    i_mdata_we,
    input  mem_wb_t i_d,
    output mem_wb_t o_q
);

    mem_wb_t r_q;

    // Register update: clear > load > bubble > hold
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q.wreg  <= i_d.wreg;
            r_q.m2reg <= i_d.m2reg;
            r_q.alu   <= i_d.alu;
            r_q.rn    <= i_d.rn;
            if (i_mdata_we) begin
                r_q.mdata <= i_d.mdata;
            end
        end else if (i_bubble) begin
            r_q.wreg  <= 1'b0;
            r_q.m2reg <= 1'b0;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage + MEM/WB register. Drives a req/ack data-memory port with
// variable latency and stalls upstream until the access completes.
// Optional: define MEM_TIMEOUT_EN to abort accesses that see no ack within
// TIMEOUT busy cycles and raise the sticky mem_err flag.
module mem_wb_stage
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          mem_wreg,
    input  logic          mem_m2reg,
    input  logic          mem_wmem,
    input  logic [DW-1:0] mem_alu,
    input  logic [DW-1:0] mem_b,
    input  logic [4:0]    mem_rn,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic          mem_stall,
    output logic          wb_wreg,
    output logic          wb_m2reg,
    output logic [DW-1:0] wb_alu,
    output logic [DW-1:0] wb_mdata,
    output logic [4:0]    wb_rn,
    output logic          mem_err
);

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("mem_wb_stage: TIMEOUT must be at least 1");
    end

    mem_state_e    r_state;
    logic          r_req;
    logic          r_we;
    logic [DW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    logic    w_access;
    logic    w_ack_done;
    logic    w_timeout;
    logic    w_wb_load;
    mem_wb_t w_wb_d;
    mem_wb_t w_wb_q;

    // A load+store combination is treated as a load
    assign w_access   = mem_m2reg | mem_wmem;
    assign w_ack_done = (r_state == MEM_BUSY) & dmem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Fires in the TIMEOUT-th busy cycle without ack; an ack in that cycle wins
    assign w_timeout = (r_state == MEM_BUSY) & ~dmem_ack &
                       (r_cnt == CNT_W'(TIMEOUT - 1));

    // Busy-cycle counter and sticky error flag
    always_ff @(posedge clk) begin
        if (clrn) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == MEM_IDLE) begin
                r_cnt <= '0;
            end else if (!dmem_ack) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // Upstream may advance when idle with no access, on ack, or on abort
    assign mem_stall = ~(((r_state == MEM_IDLE) & ~w_access) | w_ack_done | w_timeout);

    // Real writeback only for non-memory ops and acked accesses; otherwise a bubble
    assign w_wb_load = ((r_state == MEM_IDLE) & ~w_access) | w_ack_done;

    // Access sequencer with registered memory-port outputs
    always_ff @(posedge clk) begin
        if (clrn) begin
            r_state <= MEM_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                MEM_IDLE: begin
                    if (w_access) begin
                        r_state <= MEM_BUSY;
                        r_req   <= 1'b1;
                        r_we    <= mem_wmem & ~mem_m2reg;
                        r_addr  <= mem_alu;
                        r_wdata <= mem_b;
                    end
                end
                MEM_BUSY: begin
                    if (dmem_ack || w_timeout) begin
                        r_state <= MEM_IDLE;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= MEM_IDLE;
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    // Writeback payload assembled from the EXE/MEM fields and read data
    always_comb begin
        w_wb_d       = '0;
        w_wb_d.wreg  = mem_wreg;
        w_wb_d.m2reg = mem_m2reg;
        w_wb_d.alu   = DATA_W'(mem_alu);
        w_wb_d.mdata = DATA_W'(dmem_rdata);
        w_wb_d.rn    = mem_rn;
    end

    mem_wb_register u_mem_wb_register (
        .clk        (clk),
        .i_clr      (clrn),
        .i_load     (w_wb_load),
        .i_bubble   (~w_wb_load),
        .i_mdata_we (w_ack_done & mem_m2reg),
        .i_d        (w_wb_d),
        .o_q        (w_wb_q)
    );

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;

    assign wb_wreg  = w_wb_q.wreg;
    assign wb_m2reg = w_wb_q.m2reg;
    assign wb_alu   = DW'(w_wb_q.alu);
    assign wb_mdata = DW'(w_wb_q.mdata);
    assign wb_rn    = w_wb_q.rn;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage; expected writebacks are queued when an
// instruction is presented and compared when it retires.
// Build with MEM_TIMEOUT_EN defined to also exercise the timeout abort.
module tb_mem_wb_stage;

    logic        clk;
    logic        clrn;
    logic        mem_wreg, mem_m2reg, mem_wmem;
    logic [31:0] mem_alu, mem_b;
    logic [4:0]  mem_rn;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        wb_wreg, wb_m2reg;
    logic [31:0] wb_alu, wb_mdata;
    logic [4:0]  wb_rn;
    logic        mem_err;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [31:0] alu;
        logic [31:0] mdata;
        logic [4:0]  rn;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdata_model;
    int          n_cmp;
    int          n_mis;

    mem_wb_stage #(.DW(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .mem_wreg   (mem_wreg),
        .mem_m2reg  (mem_m2reg),
        .mem_wmem   (mem_wmem),
        .mem_alu    (mem_alu),
        .mem_b      (mem_b),
        .mem_rn     (mem_rn),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .mem_stall  (mem_stall),
        .wb_wreg    (wb_wreg),
        .wb_m2reg   (wb_m2reg),
        .wb_alu     (wb_alu),
        .wb_mdata   (wb_mdata),
        .wb_rn      (wb_rn),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction; optionally queue its expected writeback
    task automatic drive(input logic wreg, input logic m2reg, input logic wmem,
                         input logic [31:0] alu, input logic [31:0] b,
                         input logic [4:0] rn, input logic [31:0] rdata,
                         input bit push);
        exp_t e;
        mem_wreg  = wreg;
        mem_m2reg = m2reg;
        mem_wmem  = wmem;
        mem_alu   = alu;
        mem_b     = b;
        mem_rn    = rn;
        if (push) begin
            if (m2reg) mdata_model = rdata;
            e.wreg  = wreg;
            e.m2reg = m2reg;
            e.alu   = alu;
            e.mdata = mdata_model;
            e.rn    = rn;
            exp_q.push_back(e);
        end
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        clrn       = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        nop();
        tick();
        tick();
        clrn = 1'b0;
        mdata_model = 32'h0;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== 66'h0) begin
            n_mis++;
            $display("FAIL reset_dmem: req=%b we=%b addr=%h wdata=%h expected all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        n_cmp++;
        if ({wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn} !== 71'h0) begin
            n_mis++;
            $display("FAIL reset_wb: wreg=%b m2reg=%b alu=%h mdata=%h rn=%0d expected all 0",
                     wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn);
        end
        n_cmp++;
        if ({mem_err, mem_stall} !== 2'b00) begin
            n_mis++;
            $display("FAIL reset_err_stall: err/stall=%b expected 00", {mem_err, mem_stall});
        end
    endtask

    // ALU op with a stray ack in IDLE, which must be ignored
    task automatic test_alu();
        exp_t e;
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0042, 32'h0, 5'd5, 32'h0, 1'b1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_cmp++;
        if ({mem_stall, dmem_req} !== 2'b00) begin
            n_mis++;
            $display("FAIL alu_stall: stall/req=%b expected 00", {mem_stall, dmem_req});
        end
        tick();
        dmem_ack = 1'b0;
        nop();
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn} !== e) begin
            n_mis++;
            $display("FAIL alu_wb: got %b %b %h %h %0d expected %b %b %h %h %0d",
                     wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn,
                     e.wreg, e.m2reg, e.alu, e.mdata, e.rn);
        end
        n_cmp++;
        if ({dmem_req, mem_stall} !== 2'b00) begin
            n_mis++;
            $display("FAIL alu_idle_ack: req/stall=%b expected 00", {dmem_req, mem_stall});
        end
    endtask

    // Load with ack in the third busy cycle
    task automatic test_load_wait();
        exp_t e;
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({mem_stall, dmem_req} !== 2'b10) begin
            n_mis++;
            $display("FAIL load_detect: stall/req=%b expected 10", {mem_stall, dmem_req});
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            dmem_ack   = (k == 3);
            dmem_rdata = (k == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
            @(negedge clk);
            n_cmp++;
            if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h0000_0100}) begin
                n_mis++;
                $display("FAIL load_port k=%0d: req=%b we=%b addr=%h expected 1 0 00000100",
                         k, dmem_req, dmem_we, dmem_addr);
            end
            n_cmp++;
            if ({mem_stall, wb_wreg} !== {(k != 3), 1'b0}) begin
                n_mis++;
                $display("FAIL load_stall k=%0d: stall/wb_wreg=%b expected %b0",
                         k, {mem_stall, wb_wreg}, (k != 3));
            end
        end
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        nop();
        @(negedge clk);
        n_cmp++;
        if (dmem_req !== 1'b0) begin
            n_mis++;
            $display("FAIL load_req_drop: req=%b expected 0", dmem_req);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn} !== e) begin
            n_mis++;
            $display("FAIL load_wb: got %b %b %h %h %0d expected %b %b %h %h %0d",
                     wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn,
                     e.wreg, e.m2reg, e.alu, e.mdata, e.rn);
        end
    endtask

    // Store acked in its first busy cycle; load data must be retained
    task automatic test_store();
        exp_t e;
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_1234, 5'd3, 32'h0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (mem_stall !== 1'b1) begin
            n_mis++;
            $display("FAIL store_detect: stall=%b expected 1", mem_stall);
        end
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall} !==
            {1'b1, 1'b1, 32'h0000_0200, 32'h0000_1234, 1'b0}) begin
            n_mis++;
            $display("FAIL store_port: req=%b we=%b addr=%h wdata=%h stall=%b expected 1 1 00000200 00001234 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall);
        end
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        nop();
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, dmem_we} !== 2'b00) begin
            n_mis++;
            $display("FAIL store_drop: req/we=%b expected 00", {dmem_req, dmem_we});
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn} !== e) begin
            n_mis++;
            $display("FAIL store_wb: got %b %b %h %h %0d expected %b %b %h %h %0d",
                     wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn,
                     e.wreg, e.m2reg, e.alu, e.mdata, e.rn);
        end
    endtask

    // Two loads back to back, each acked in its first busy cycle
    task automatic test_back_to_back();
        exp_t e;
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd8, 32'h1111_AAAA, 1'b1);
        @(negedge clk);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_AAAA;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, dmem_addr, mem_stall} !== {1'b1, 32'h0000_0300, 1'b0}) begin
            n_mis++;
            $display("FAIL b2b_first_req: req=%b addr=%h stall=%b expected 1 00000300 0",
                     dmem_req, dmem_addr, mem_stall);
        end
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0304, 32'h0, 5'd9, 32'h2222_BBBB, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, mem_stall} !== 2'b01) begin
            n_mis++;
            $display("FAIL b2b_gap: req/stall=%b expected 01", {dmem_req, mem_stall});
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn} !== e) begin
            n_mis++;
            $display("FAIL b2b_wb_first: got %b %b %h %h %0d expected %b %b %h %h %0d",
                     wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn,
                     e.wreg, e.m2reg, e.alu, e.mdata, e.rn);
        end
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h2222_BBBB;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, dmem_addr, wb_wreg} !== {1'b1, 32'h0000_0304, 1'b0}) begin
            n_mis++;
            $display("FAIL b2b_second_req: req=%b addr=%h wb_wreg=%b expected 1 00000304 0",
                     dmem_req, dmem_addr, wb_wreg);
        end
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        nop();
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn} !== e) begin
            n_mis++;
            $display("FAIL b2b_wb_second: got %b %b %h %h %0d expected %b %b %h %h %0d",
                     wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn,
                     e.wreg, e.m2reg, e.alu, e.mdata, e.rn);
        end
    endtask

    // Reset in the second busy cycle, ack arriving one cycle late
    task automatic test_reset_mid_access();
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd10, 32'h5555_5555, 1'b0);
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        clrn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dmem_req !== 1'b1) begin
            n_mis++;
            $display("FAIL rst_mid_pre: req=%b expected 1", dmem_req);
        end
        tick();
        clrn        = 1'b0;
        mdata_model = 32'h0;
        nop();
        dmem_ack    = 1'b1;
        dmem_rdata  = 32'h5555_5555;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_err} !== 67'h0) begin
            n_mis++;
            $display("FAIL rst_mid_dmem: req=%b we=%b addr=%h wdata=%h err=%b expected all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_err);
        end
        n_cmp++;
        if ({wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn} !== 71'h0) begin
            n_mis++;
            $display("FAIL rst_mid_wb: wreg=%b m2reg=%b alu=%h mdata=%h rn=%0d expected all 0",
                     wb_wreg, wb_m2reg, wb_alu, wb_mdata, wb_rn);
        end
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        @(negedge clk);
        n_cmp++;
        if ({wb_wreg, wb_mdata, dmem_req, mem_stall} !== 35'h0) begin
            n_mis++;
            $display("FAIL rst_late_ack: wb_wreg=%b wb_mdata=%h req=%b stall=%b expected all 0",
                     wb_wreg, wb_mdata, dmem_req, mem_stall);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after TIMEOUT=4 busy cycles, sticky error until reset
    task automatic test_timeout();
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd11, 32'h0, 1'b0);
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            tick();
            @(negedge clk);
            n_cmp++;
            if ({dmem_req, mem_stall, mem_err} !== {1'b1, (k != 4), 1'b0}) begin
                n_mis++;
                $display("FAIL tmo_busy k=%0d: req/stall/err=%b expected 1%b0",
                         k, {dmem_req, mem_stall, mem_err}, (k != 4));
            end
        end
        tick();
        nop();
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, mem_err, wb_wreg, mem_stall} !== 4'b0100) begin
            n_mis++;
            $display("FAIL tmo_abort: req/err/wb_wreg/stall=%b expected 0100",
                     {dmem_req, mem_err, wb_wreg, mem_stall});
        end
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if (mem_err !== 1'b1) begin
            n_mis++;
            $display("FAIL tmo_sticky: err=%b expected 1", mem_err);
        end
        tick();
        clrn = 1'b1;
        tick();
        clrn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_err !== 1'b0) begin
            n_mis++;
            $display("FAIL tmo_clear: err=%b expected 0", mem_err);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_mis = 0;
        mdata_model = 32'h0;
        test_reset();
        test_alu();
        test_load_wait();
        test_store();
        test_back_to_back();
        test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_mis++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
